mood_display_seq: RTL and testbench

//   Downstream consumer of the pet mood/status stage. Pages the 7-bit status word and the six 4-bit

---
 rtl/mood_display_seq_pkg.sv | 31 +++
 rtl/mood_display_seq_if.sv | 27 ++
 rtl/mood_display_seq_seg7.sv | 11 +
 rtl/mood_display_seq.sv | 136 +++++++++++++
 tb/tb_mood_display_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mood_display_seq_pkg.sv
// Shared display-stage types and constants: FSM states, page numbers,
// blank pattern and the hex-digit segment lookup.
package mood_display_seq_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_ALERT = 1'b1
  } state_t;

  localparam logic [2:0] PG_STATUS    = 3'd0;
  localparam logic [2:0] PG_HUNGER    = 3'd1;
  localparam logic [2:0] PG_HAPPINESS = 3'd2;
  localparam logic [2:0] PG_HEALTH    = 3'd3;
  localparam logic [2:0] PG_HYGIENE   = 3'd4;
  localparam logic [2:0] PG_ENERGY    = 3'd5;
  localparam logic [2:0] PG_SOCIAL    = 3'd6;
  localparam logic [2:0] PG_ALERT     = 3'd7;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Segment patterns {g,f,e,d,c,b,a}; element n is the glyph for digit n.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex7(input logic [3:0] value);
    return HEX7_TABLE[value];
  endfunction

endpackage

// File: rtl/mood_display_seq_if.sv
// Display-stage bundle: live pet stats in, registered display drive out.
interface mood_display_seq_if;
  import mood_display_seq_pkg::*;

  logic       hold;
  logic [6:0] status;
  logic [3:0] hunger;
  logic [3:0] happiness;
  logic [3:0] health;
  logic [3:0] hygiene;
  logic [3:0] energy;
  logic [3:0] social;
  logic [6:0] seg_out;
  logic       dp;
  logic [2:0] page_idx;
  logic       alert;

  modport master (
    output hold, status, hunger, happiness, health, hygiene, energy, social,
    input  seg_out, dp, page_idx, alert
  );

  modport slave (
    input  hold, status, hunger, happiness, health, hygiene, energy, social,
    output seg_out, dp, page_idx, alert
  );
endinterface

// File: rtl/mood_display_seq_seg7.sv
// Combinational hex digit to 7-segment encoder, shared by display stages.
module seg7_hex_encoder
  import mood_display_seq_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = hex7(value);

endmodule

// File: rtl/mood_display_seq.sv
// Pages the mood pattern and six stats onto the 7-segment display, one page
// per dwell tick, and pre-empts rotation with a blinking health alert while
// the pet is critical.
module mood_display_seq
  import mood_display_seq_pkg::*;
#(
  parameter logic [23:0] TICK_COUNT  = 24'd10_000_000,
  parameter logic [3:0]  HUNGER_CRIT = 4'd12,
  parameter logic [3:0]  HEALTH_CRIT = 4'd3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  mood_display_seq_if.slave   disp
);

  logic [23:0] tick_cnt;
  logic        tick;
  logic        crit;
  state_t      state;
  logic [2:0]  page;
  logic        blink;

  logic [3:0]  nibble;
  logic [6:0]  hex_seg;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;
  logic [2:0]  idx_nxt;

  logic [6:0]  seg_p1;
  logic        dp_p1;
  logic [2:0]  idx_p1;
  logic        alert_p1;

  assign tick = ena && (tick_cnt == TICK_COUNT - 24'd1);
  assign crit = (disp.hunger >= HUNGER_CRIT) || (disp.health <= HEALTH_CRIT);

  // Dwell divider: free-runs while enabled and wraps on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (ena) begin
      tick_cnt <= tick ? 24'd0 : tick_cnt + 24'd1;
    end
  end

  // Page/alert FSM, advanced only on dwell ticks; alert overrides hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SHOW;
      page  <= PG_STATUS;
      blink <= 1'b0;
    end else if (tick) begin
      unique case (state)
        ST_SHOW: begin
          if (crit) begin
            state <= ST_ALERT;
            blink <= 1'b1;
          end else if (!disp.hold) begin
            page <= (page == PG_SOCIAL) ? PG_STATUS : page + 3'd1;
          end
        end
        ST_ALERT: begin
          if (!crit) begin
            state <= ST_SHOW;
            page  <= PG_STATUS;
            blink <= 1'b0;
          end else begin
            blink <= ~blink;
          end
        end
        default: state <= ST_SHOW;
      endcase
    end
  end

  // Pick the nibble to render: health during alert, else the page's stat.
  always_comb begin
    nibble = 4'h0;
    if (state == ST_ALERT) begin
      nibble = disp.health;
    end else begin
      case (page)
        PG_HUNGER:    nibble = disp.hunger;
        PG_HAPPINESS: nibble = disp.happiness;
        PG_HEALTH:    nibble = disp.health;
        PG_HYGIENE:   nibble = disp.hygiene;
        PG_ENERGY:    nibble = disp.energy;
        PG_SOCIAL:    nibble = disp.social;
        default:      nibble = 4'h0;
      endcase
    end
  end

  seg7_hex_encoder u_hex (
    .value (nibble),
    .seg   (hex_seg)
  );

  // Output mux: raw mood on page 0, hex stat elsewhere, blinking health in alert.
  always_comb begin
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b0;
    idx_nxt = page;
    if (state == ST_ALERT) begin
      seg_nxt = blink ? hex_seg : SEG_BLANK;
      idx_nxt = PG_ALERT;
    end else if (page == PG_STATUS) begin
      seg_nxt = disp.status;
    end else begin
      seg_nxt = hex_seg;
      dp_nxt  = 1'b1;
    end
  end

  // Output registers refresh every enabled cycle so live stat edits show next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1   <= SEG_BLANK;
      dp_p1    <= 1'b0;
      idx_p1   <= PG_STATUS;
      alert_p1 <= 1'b0;
    end else if (ena) begin
      seg_p1   <= seg_nxt;
      dp_p1    <= dp_nxt;
      idx_p1   <= idx_nxt;
      alert_p1 <= (state == ST_ALERT);
    end
  end

  assign disp.seg_out  = seg_p1;
  assign disp.dp       = dp_p1;
  assign disp.page_idx = idx_p1;
  assign disp.alert    = alert_p1;

endmodule

// File: tb/tb_mood_display_seq.sv
// Bench for mood_display_seq with a short dwell: directed vector table,
// hand-written reset corner cases, then randomized traffic against a
// cycle-level reference model.
module tb_mood_display_seq;

  localparam int TC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;

  mood_display_seq_if bus();

  mood_display_seq #(
    .TICK_COUNT  (24'd4),
    .HUNGER_CRIT (4'd12),
    .HEALTH_CRIT (4'd3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .disp  (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] hex_tb [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state, in plain ints/bits.
  int         m_cnt;
  bit         m_in_alert;
  int         m_page;
  bit         m_blink;
  logic [6:0] m_seg;
  logic       m_dp;
  logic [2:0] m_idx;
  logic       m_al;

  typedef struct {
    logic [6:0] status;
    logic [3:0] hunger, happiness, health, hygiene, energy, social;
    logic       hold, en;
    int         cycles;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
    logic       al;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic [3:0] hun, logic [3:0] hea, logic hd, logic en, int cyc,
                              logic [6:0] s, logic d, logic [2:0] i, logic a);
    vec_t v;
    v.status = 7'h2A; v.hunger = hun; v.happiness = 4'h8; v.health = hea;
    v.hygiene = 4'h8; v.energy = 4'h8; v.social = 4'h8;
    v.hold = hd; v.en = en; v.cycles = cyc;
    v.seg = s; v.dp = d; v.idx = i; v.al = a;
    return v;
  endfunction

  function automatic bit is_crit();
    return (bus.hunger >= 4'd12) || (bus.health <= 4'd3);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_in_alert = 0; m_page = 0; m_blink = 0;
    m_seg = 7'h00; m_dp = 0; m_idx = 3'd0; m_al = 0;
  endtask

  // One clock edge of the display behaviour, from the current inputs.
  task automatic model_edge();
    logic [3:0] st [7];
    bit t;
    if (!ena) return;
    st[0] = 4'h0;       st[1] = bus.hunger; st[2] = bus.happiness; st[3] = bus.health;
    st[4] = bus.hygiene; st[5] = bus.energy; st[6] = bus.social;
    if (m_in_alert) begin
      m_seg = m_blink ? hex_tb[bus.health] : 7'h00;
      m_dp = 0; m_idx = 3'd7; m_al = 1;
    end else begin
      m_seg = (m_page == 0) ? bus.status : hex_tb[st[m_page]];
      m_dp = (m_page != 0); m_idx = 3'(m_page); m_al = 0;
    end
    t = (m_cnt == TC - 1);
    m_cnt = t ? 0 : m_cnt + 1;
    if (t) begin
      if (!m_in_alert) begin
        if (is_crit()) begin m_in_alert = 1; m_blink = 1; end
        else if (!bus.hold) m_page = (m_page + 1) % 7;
      end else begin
        if (!is_crit()) begin m_in_alert = 0; m_page = 0; m_blink = 0; end
        else m_blink = !m_blink;
      end
    end
  endtask

  task automatic check(string name, logic [6:0] es, logic edp, logic [2:0] ei, logic eal);
    vectors++;
    if ({bus.seg_out, bus.dp, bus.page_idx, bus.alert} !== {es, edp, ei, eal}) begin
      miscompares++;
      $display("FAIL %s @%0t: got seg=%h dp=%b idx=%0d alert=%b, expected seg=%h dp=%b idx=%0d alert=%b",
               name, $time, bus.seg_out, bus.dp, bus.page_idx, bus.alert, es, edp, ei, eal);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model", m_seg, m_dp, m_idx, m_al);
  endtask

  // Called 1ns after an edge: async reset must clear outputs before the next edge.
  task automatic reset_mid();
    rst_n = 1'b0;
    #2;
    check("async_reset", 7'h00, 1'b0, 3'd0, 1'b0);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic apply(vec_t v);
    bus.status = v.status; bus.hunger = v.hunger; bus.happiness = v.happiness;
    bus.health = v.health; bus.hygiene = v.hygiene; bus.energy = v.energy;
    bus.social = v.social; bus.hold = v.hold; ena = v.en;
  endtask

  initial begin
    vecs[0]  = mk(4'hA, 4'h8, 0, 1, 1,  7'h2A, 0, 3'd0, 0);
    vecs[1]  = mk(4'hA, 4'h8, 0, 1, 4,  7'h77, 1, 3'd1, 0);
    vecs[2]  = mk(4'hA, 4'h8, 0, 1, 20, 7'h7F, 1, 3'd6, 0);
    vecs[3]  = mk(4'hA, 4'h8, 0, 1, 4,  7'h2A, 0, 3'd0, 0);
    vecs[4]  = mk(4'hA, 4'h8, 0, 1, 8,  7'h7F, 1, 3'd2, 0);
    vecs[5]  = mk(4'hA, 4'h2, 0, 1, 4,  7'h5B, 0, 3'd7, 1);
    vecs[6]  = mk(4'hA, 4'h2, 0, 1, 4,  7'h00, 0, 3'd7, 1);
    vecs[7]  = mk(4'hA, 4'h2, 0, 1, 4,  7'h5B, 0, 3'd7, 1);
    vecs[8]  = mk(4'hA, 4'h8, 0, 1, 4,  7'h2A, 0, 3'd0, 0);
    vecs[9]  = mk(4'hC, 4'h8, 1, 1, 4,  7'h7F, 0, 3'd7, 1);
    vecs[10] = mk(4'hA, 4'h8, 0, 1, 4,  7'h2A, 0, 3'd0, 0);
    vecs[11] = mk(4'hA, 4'h8, 0, 1, 12, 7'h7F, 1, 3'd3, 0);
    vecs[12] = mk(4'hA, 4'h8, 1, 1, 20, 7'h7F, 1, 3'd3, 0);
    vecs[13] = mk(4'hA, 4'h9, 1, 1, 1,  7'h6F, 1, 3'd3, 0);
    vecs[14] = mk(4'hA, 4'h8, 0, 1, 3,  7'h7F, 1, 3'd4, 0);
    vecs[15] = mk(4'hA, 4'h8, 0, 0, 20, 7'h7F, 1, 3'd4, 0);
    vecs[16] = mk(4'hA, 4'h8, 0, 1, 3,  7'h7F, 1, 3'd4, 0);
    vecs[17] = mk(4'hA, 4'h8, 0, 1, 1,  7'h7F, 1, 3'd5, 0);

    // Power-up in reset.
    apply(vecs[0]);
    ena = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 7'h00, 1'b0, 3'd0, 1'b0);
    #3;
    rst_n = 1'b1;
    apply(vecs[0]);

    // Directed table: rotation, alert, hunger alert over hold, hold, ena freeze.
    for (int i = 0; i < 18; i++) begin
      apply(vecs[i]);
      for (int c = 0; c < vecs[i].cycles; c++) step();
      check($sformatf("vec%0d", i), vecs[i].seg, vecs[i].dp, vecs[i].idx, vecs[i].al);
    end

    // Reset mid-dwell, then counting restarts from zero.
    step();
    reset_mid();
    for (int c = 0; c < 4; c++) step();
    check("post_reset_dwell", 7'h2A, 1'b0, 3'd0, 1'b0);
    step();
    check("post_reset_tick", 7'h77, 1'b1, 3'd1, 1'b0);

    // Reset mid-alert.
    bus.health = 4'h1;
    for (int c = 0; c < 5; c++) step();
    check("alert_before_reset", 7'h06, 1'b0, 3'd7, 1'b1);
    reset_mid();
    bus.health = 4'h8;
    step();
    check("after_alert_reset", 7'h2A, 1'b0, 3'd0, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.status    = 7'($urandom);
        bus.hunger    = 4'($urandom_range(0, 13));
        bus.happiness = 4'($urandom);
        bus.health    = 4'($urandom_range(2, 15));
        bus.hygiene   = 4'($urandom);
        bus.energy    = 4'($urandom);
        bus.social    = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) bus.hold = ~bus.hold;
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 499) == 0) reset_mid();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
